// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I-subset datapath: steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB with req/ack memory handshakes and a wait timeout.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic       Zero,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [2:0] NPCOp,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [2:0] state,
  output logic       illegal,
  output logic       bus_err,
  output logic       retired
);

  // Memory handshake: a request (imem_req/dmem_req) is held high every cycle
  // of its phase; the cycle in which the matching ack is high completes it.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BEQ, C_JAL, C_JALR, C_ILLEGAL
  } cls_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  cls_t             cls_q, dec_cls;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;

  assign state   = state_q;
  assign timeout = (cnt_q == CNT_LIMIT);

  always_comb begin
    dec_cls = C_ILLEGAL;
    case (Op)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = (Funct3 == 3'b000) ? C_BEQ : C_ILLEGAL;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      default:    dec_cls = C_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_DECODE) cls_q <= dec_cls;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    NPCOp    = 3'b000;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    illegal  = 1'b0;
    bus_err  = 1'b0;
    retired  = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          bus_err = 1'b1;  // PC untouched, so the same address is re-fetched
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_cls == C_ILLEGAL) begin
          illegal = 1'b1;
          PCWrite = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BEQ: begin
            PCWrite = 1'b1;
            NPCOp   = Zero ? 3'b001 : 3'b000;
            retired = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        MemWrite = (cls_q == C_STORE);
        if (dmem_ack) begin
          if (cls_q == C_STORE) begin
            PCWrite = 1'b1;
            retired = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          MemWrite = 1'b0;  // aborted access must not commit a store
          bus_err  = 1'b1;
          PCWrite  = 1'b1;
          state_d  = S_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        retired  = 1'b1;
        NPCOp    = (cls_q == C_JAL) ? 3'b010 : (cls_q == C_JALR) ? 3'b100 : 3'b000;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset suppresses every enable and request in the cycle it is asserted.
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      NPCOp    = 3'b000;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      illegal  = 1'b0;
      bus_err  = 1'b0;
      retired  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Cycle-by-cycle directed checks of multicycle_ctrl: a vector table for the
// normal instruction flows plus hand-written timeout and reset sequences.
module tb_multicycle_ctrl;

  localparam int MEM_TIMEOUT = 4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       zero = 1'b0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       imem_req, dmem_req, ir_write, pc_write, reg_write, mem_write;
  logic       illegal, bus_err, retired;
  logic [2:0] npc_op, state;

  multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .Op(op), .Funct3(funct3), .Zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(ir_write),
    .PCWrite(pc_write), .NPCOp(npc_op), .RegWrite(reg_write),
    .MemWrite(mem_write), .state(state), .illegal(illegal),
    .bus_err(bus_err), .retired(retired)
  );

  always #5 clk = ~clk;

  // Packed output word: {state, imem_req, dmem_req, IRWrite, PCWrite, NPCOp,
  // RegWrite, MemWrite, illegal, bus_err, retired}
  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        zero;
    logic        iack;
    logic        dack;
    logic [14:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [14:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [14:0] o(input int st, input bit ireq, input bit dreq,
                                    input bit irw, input bit pcw, input int npc,
                                    input bit rw, input bit mw, input bit ill,
                                    input bit berr, input bit ret);
    return {3'(st), ireq, dreq, irw, pcw, 3'(npc), rw, mw, ill, berr, ret};
  endfunction

  function automatic void add(input logic r, input logic [6:0] opc, input logic [2:0] f3,
                              input logic z, input logic ia, input logic da,
                              input logic [14:0] e);
    vec_t v;
    v.rst = r; v.op = opc; v.f3 = f3; v.zero = z; v.iack = ia; v.dack = da; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic apply(input vec_t v, input string name);
    logic [14:0] got, exp;
    @(negedge clk);
    rst = v.rst; op = v.op; funct3 = v.f3; zero = v.zero;
    imem_ack = v.iack; dmem_ack = v.dack;
    exp_q.push_back(v.exp);
    #1;
    got = {state, imem_req, dmem_req, ir_write, pc_write, npc_op,
           reg_write, mem_write, illegal, bus_err, retired};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (state npc fields: %0d/%0d vs %0d/%0d)",
               name, got, exp, got[14:12], got[7:5], exp[14:12], exp[7:5]);
    end
  endtask

  task automatic cyc(input string name, input logic r, input logic [6:0] opc,
                     input logic z, input logic ia, input logic da, input logic [14:0] e);
    vec_t v;
    v.rst = r; v.op = opc; v.f3 = 3'b000; v.zero = z; v.iack = ia; v.dack = da; v.exp = e;
    apply(v, name);
  endtask

  logic [14:0] f_wait, f_ack, dec, exe, idle, mem_ld, mem_st, wb0;

  initial begin
    f_wait = o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    f_ack  = o(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    dec    = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exe    = o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle   = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_ld = o(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_st = o(3, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    wb0    = o(4, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1);

    // reset held, then R-type with imem_ack two cycles late
    add(1, OP_R, 0, 0, 0, 0, idle);
    add(0, OP_R, 0, 0, 0, 0, f_wait);
    add(0, OP_R, 0, 0, 0, 0, f_wait);
    add(0, OP_R, 0, 0, 1, 0, f_ack);
    add(0, OP_R, 0, 0, 0, 0, dec);
    add(0, OP_R, 0, 0, 0, 0, exe);
    add(0, OP_R, 0, 0, 0, 0, wb0);
    // LOAD, ack on third MEM cycle
    add(0, OP_LD, 0, 0, 1, 0, f_ack);
    add(0, OP_LD, 0, 0, 0, 0, dec);
    add(0, OP_LD, 0, 0, 0, 0, exe);
    add(0, OP_LD, 0, 0, 0, 0, mem_ld);
    add(0, OP_LD, 0, 0, 0, 0, mem_ld);
    add(0, OP_LD, 0, 0, 0, 1, mem_ld);
    add(0, OP_LD, 0, 0, 0, 0, wb0);
    // STORE, ack on second MEM cycle
    add(0, OP_ST, 0, 0, 1, 0, f_ack);
    add(0, OP_ST, 0, 0, 0, 0, dec);
    add(0, OP_ST, 0, 0, 0, 0, exe);
    add(0, OP_ST, 0, 0, 0, 0, mem_st);
    add(0, OP_ST, 0, 0, 0, 1, o(3, 0, 1, 0, 1, 0, 0, 1, 0, 0, 1));
    // BEQ taken / not taken
    add(0, OP_BR, 0, 1, 1, 0, f_ack);
    add(0, OP_BR, 0, 1, 0, 0, dec);
    add(0, OP_BR, 0, 1, 0, 0, o(2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    add(0, OP_BR, 0, 0, 1, 0, f_ack);
    add(0, OP_BR, 0, 0, 0, 0, dec);
    add(0, OP_BR, 0, 0, 0, 0, o(2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    // JAL, JALR, I-ALU
    add(0, OP_JAL, 0, 0, 1, 0, f_ack);
    add(0, OP_JAL, 0, 0, 0, 0, dec);
    add(0, OP_JAL, 0, 0, 0, 0, exe);
    add(0, OP_JAL, 0, 0, 0, 0, o(4, 0, 0, 0, 1, 2, 1, 0, 0, 0, 1));
    add(0, OP_JALR, 0, 0, 1, 0, f_ack);
    add(0, OP_JALR, 0, 0, 0, 0, dec);
    add(0, OP_JALR, 0, 0, 0, 0, exe);
    add(0, OP_JALR, 0, 0, 0, 0, o(4, 0, 0, 0, 1, 4, 1, 0, 0, 0, 1));
    add(0, OP_I, 0, 0, 1, 0, f_ack);
    add(0, OP_I, 0, 0, 0, 0, dec);
    add(0, OP_I, 0, 0, 0, 0, exe);
    add(0, OP_I, 0, 0, 0, 0, wb0);
    // illegal: LUI, and branch opcode with funct3 != 000
    add(0, OP_LUI, 0, 0, 1, 0, f_ack);
    add(0, OP_LUI, 0, 0, 0, 0, o(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    add(0, OP_BR, 1, 0, 1, 0, f_ack);
    add(0, OP_BR, 1, 0, 0, 0, o(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    add(0, OP_R, 0, 0, 0, 0, f_wait);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // STORE with dmem_ack never arriving: abort on 4th MEM cycle
    cyc("st_to_fetch", 0, OP_ST, 0, 1, 0, f_ack);
    cyc("st_to_dec", 0, OP_ST, 0, 0, 0, dec);
    cyc("st_to_exec", 0, OP_ST, 0, 0, 0, exe);
    for (int i = 0; i < 3; i++) cyc($sformatf("st_to_mem%0d", i), 0, OP_ST, 0, 0, 0, mem_st);
    cyc("st_to_abort", 0, OP_ST, 0, 0, 0, o(3, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0));
    cyc("st_to_after", 0, OP_LD, 0, 1, 0, f_ack);
    // LOAD with ack exactly at the limit: ack wins
    cyc("ld_lim_dec", 0, OP_LD, 0, 0, 0, dec);
    cyc("ld_lim_exec", 0, OP_LD, 0, 0, 0, exe);
    for (int i = 0; i < 3; i++) cyc($sformatf("ld_lim_mem%0d", i), 0, OP_LD, 0, 0, 0, mem_ld);
    cyc("ld_lim_ack", 0, OP_LD, 0, 0, 1, mem_ld);
    cyc("ld_lim_wb", 0, OP_LD, 0, 0, 0, wb0);
    // FETCH timeout re-fetches without PCWrite, then counter restarts
    for (int i = 0; i < 3; i++) cyc($sformatf("if_to_wait%0d", i), 0, OP_R, 0, 0, 0, f_wait);
    cyc("if_to_abort", 0, OP_R, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++) cyc($sformatf("if_re_wait%0d", i), 0, OP_R, 0, 0, 0, f_wait);
    cyc("if_lim_ack", 0, OP_R, 0, 1, 0, f_ack);
    cyc("if_lim_dec", 0, OP_R, 0, 0, 0, dec);
    cyc("if_lim_exec", 0, OP_R, 0, 0, 0, exe);
    cyc("if_lim_wb", 0, OP_R, 0, 0, 0, wb0);
    // reset during STORE MEM phase
    cyc("rst_fetch", 0, OP_ST, 0, 1, 0, f_ack);
    cyc("rst_dec", 0, OP_ST, 0, 0, 0, dec);
    cyc("rst_exec", 0, OP_ST, 0, 0, 0, exe);
    cyc("rst_mem", 0, OP_ST, 0, 0, 0, mem_st);
    cyc("rst_assert", 1, OP_ST, 0, 0, 1, o(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("rst_after", 0, OP_ST, 0, 0, 0, f_wait);
    cyc("rst_after2", 0, OP_ST, 0, 0, 0, f_wait);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
